// File: rtl/sccb_pkg.sv
// sccb_pkg: shared constants, FSM state encoding and write payload type for
// the SCCB target.
package sccb_pkg;

   localparam logic [7:0] SCCB_CAM_ADDR = 8'h42;   // camera write address
   localparam logic [7:0] SCCB_RD_BIT   = 8'h01;   // OR-ed in for the read address
   localparam logic [3:0] BIT_ACK       = 4'd8;    // 9th bit of a byte (ack / NA)

   typedef enum logic [2:0] {
      IDLE,
      DEV,
      SUBA,
      WDAT,
      RD,
      IGNORE
   } sccb_state_e;

   // Register write request presented to the external store.
   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } sccb_wr_t;

endpackage

// File: rtl/sccb_line_sync.sv
// sccb_line_sync: brings the asynchronous SIOC/SIOD lines into the clk domain
// (2-FF synchroniser plus one delay flop) and derives bus events.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   sioc_in, siod_in   raw bus lines
//   siod_s             synchronised SIOD (registered)
//   rise_c, fall_c     SIOC edge pulses, one clk wide
//   start_c, stop_c    START / STOP condition pulses, one clk wide
module sccb_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic sioc_in,
   input  logic siod_in,
   output logic siod_s,
   output logic rise_c,
   output logic fall_c,
   output logic start_c,
   output logic stop_c
);

   logic sioc_meta_q, sioc_sync_q, sioc_dly_q;
   logic siod_meta_q, siod_sync_q, siod_dly_q;
   logic sioc_meta_d, sioc_sync_d, sioc_dly_d;
   logic siod_meta_d, siod_sync_d, siod_dly_d;

   // Pipeline inputs for the synchroniser and delay stages.
   always_comb begin
      sioc_meta_d = sioc_in;
      sioc_sync_d = sioc_meta_q;
      sioc_dly_d  = sioc_sync_q;
      siod_meta_d = siod_in;
      siod_sync_d = siod_meta_q;
      siod_dly_d  = siod_sync_q;
   end

   // Reset to 1 so an idle bus produces no spurious edges after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sioc_meta_q <= 1'b1;
         sioc_sync_q <= 1'b1;
         sioc_dly_q  <= 1'b1;
         siod_meta_q <= 1'b1;
         siod_sync_q <= 1'b1;
         siod_dly_q  <= 1'b1;
      end else begin
         sioc_meta_q <= sioc_meta_d;
         sioc_sync_q <= sioc_sync_d;
         sioc_dly_q  <= sioc_dly_d;
         siod_meta_q <= siod_meta_d;
         siod_sync_q <= siod_sync_d;
         siod_dly_q  <= siod_dly_d;
      end
   end

   // START/STOP require SIOC high on both sides of the SIOD transition.
   always_comb begin
      siod_s  = siod_sync_q;
      rise_c  =  sioc_sync_q & ~sioc_dly_q;
      fall_c  = ~sioc_sync_q &  sioc_dly_q;
      start_c =  sioc_sync_q &  sioc_dly_q &  siod_dly_q & ~siod_sync_q;
      stop_c  =  sioc_sync_q &  sioc_dly_q & ~siod_dly_q &  siod_sync_q;
   end

endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB responder emulating a camera control port.
// Accepts 3-phase writes and 2-phase sub-address writes, answers 2-phase
// reads from an external register store.
// Optional build macro SCCB_ACK_DRIVE_EN: pull SIOD low during the 9th bit
// of matched DEV, SUBA and WDAT bytes (otherwise the ack bit is released).
// Ports:
//   clk, rst_n         clock (>= 16x SIOC), asynchronous active-low reset
//   sioc_in, siod_in   asynchronous bus lines
//   siod_oe            1 = pull SIOD low, 0 = release
//   wr_en/addr/data    one-cycle register write strobe and payload
//   rd_addr, rd_data   read lookup address, store data (1 clk latency)
//   busy               address matched, transaction in progress
module sccb_target
   import sccb_pkg::*;
#(
   parameter logic [7:0]  DEV_ADDR    = SCCB_CAM_ADDR,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sioc_in,
   input  logic       siod_in,
   output logic       siod_oe,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy
);

`ifdef SCCB_ACK_DRIVE_EN
   localparam bit ACK_DRIVE = 1'b1;
`else
   localparam bit ACK_DRIVE = 1'b0;
`endif

   localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
   localparam logic [7:0]  RD_ADDR = DEV_ADDR | SCCB_RD_BIT;

   logic siod_s, rise_c, fall_c, start_c, stop_c;

   sccb_line_sync u_line_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .sioc_in (sioc_in),
      .siod_in (siod_in),
      .siod_s  (siod_s),
      .rise_c  (rise_c),
      .fall_c  (fall_c),
      .start_c (start_c),
      .stop_c  (stop_c)
   );

   sccb_state_e       state_q, state_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        rx_q, rx_d;
   logic [7:0]        tx_q, tx_d;
   logic [7:0]        sub_addr_q, sub_addr_d;
   logic [7:0]        rd_addr_q, rd_addr_d;
   sccb_wr_t          wr_q, wr_d;
   logic              wr_en_q, wr_en_d;
   logic              busy_q, busy_d;
   logic              oe_q, oe_d;
   logic              oe_pend_q, oe_pend_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              reload_q, reload_d;
   logic [7:0]        rx_byte_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         sub_addr_q <= '0;
         rd_addr_q  <= '0;
         wr_q       <= '0;
         wr_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         oe_q       <= 1'b0;
         oe_pend_q  <= 1'b0;
         hold_cnt_q <= '0;
         reload_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         sub_addr_q <= sub_addr_d;
         rd_addr_q  <= rd_addr_d;
         wr_q       <= wr_d;
         wr_en_q    <= wr_en_d;
         busy_q     <= busy_d;
         oe_q       <= oe_d;
         oe_pend_q  <= oe_pend_d;
         hold_cnt_q <= hold_cnt_d;
         reload_q   <= reload_d;
      end
   end

   // Next-state and output logic. SIOD changes are decided on an SIOC fall
   // and applied HOLD_CYCLES clocks later, so they never land while SIOC=1.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_d       = rx_q;
      tx_d       = tx_q;
      sub_addr_d = sub_addr_q;
      rd_addr_d  = rd_addr_q;
      wr_d       = wr_q;
      wr_en_d    = 1'b0;
      busy_d     = busy_q;
      oe_d       = oe_q;
      oe_pend_d  = oe_pend_q;
      hold_cnt_d = hold_cnt_q;
      reload_d   = reload_q;
      rx_byte_c  = {rx_q[6:0], siod_s};

      // Data-hold timer: apply the pending SIOD value when it expires.
      if (hold_cnt_q != '0) begin
         hold_cnt_d = hold_cnt_q - HOLD_W'(1);
         if (hold_cnt_q == HOLD_W'(1)) begin
            oe_d = oe_pend_q;
         end
      end

      if (stop_c) begin
         state_d    = IDLE;
         bit_cnt_d  = '0;
         busy_d     = 1'b0;
         oe_d       = 1'b0;
         hold_cnt_d = '0;
         reload_d   = 1'b0;
      end else if (start_c) begin
         state_d    = DEV;
         bit_cnt_d  = '0;
         busy_d     = 1'b0;
         oe_d       = 1'b0;
         hold_cnt_d = '0;
         reload_d   = 1'b0;
      end else if (state_q == IDLE || state_q == IGNORE) begin
         oe_d       = 1'b0;
         hold_cnt_d = '0;
      end else if (rise_c) begin
         if (bit_cnt_q != BIT_ACK) begin
            // Data bit: shift MSB first; act on the 8th bit.
            rx_d      = rx_byte_c;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
               case (state_q)
                  DEV: begin
                     if (rx_byte_c == DEV_ADDR) begin
                        busy_d = 1'b1;
                     end else if (rx_byte_c == RD_ADDR) begin
                        busy_d = 1'b1;
                        tx_d   = rd_data;
                     end else begin
                        state_d = IGNORE;
                     end
                  end
                  SUBA: begin
                     sub_addr_d = rx_byte_c;
                     rd_addr_d  = rx_byte_c;
                  end
                  WDAT: begin
                     wr_en_d   = 1'b1;
                     wr_d.addr = sub_addr_q;
                     wr_d.data = rx_byte_c;
                  end
                  default: ;
               endcase
            end
         end else begin
            // Ack / NA bit closes the byte.
            bit_cnt_d = '0;
            case (state_q)
               DEV:  state_d = (rx_q == RD_ADDR) ? RD : SUBA;
               SUBA: state_d = WDAT;
               WDAT: sub_addr_d = sub_addr_q + 8'd1;
               RD: begin
                  if (siod_s) begin
                     state_d = IGNORE;
                  end else begin
                     sub_addr_d = sub_addr_q + 8'd1;
                     rd_addr_d  = sub_addr_q + 8'd1;
                     reload_d   = 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end else if (fall_c) begin
         hold_cnt_d = HOLD_W'(HOLD_CYCLES);
         if (bit_cnt_q == BIT_ACK) begin
            // Ack of a received byte, or release for the master's NA.
            oe_pend_d = ACK_DRIVE && (state_q != RD);
         end else if (state_q == RD) begin
            if (reload_q) begin
               // rd_data has settled for the incremented rd_addr by now.
               tx_d      = rd_data;
               reload_d  = 1'b0;
               oe_pend_d = ~rd_data[7];
            end else begin
               oe_pend_d = ~tx_q[~bit_cnt_q[2:0]];
            end
         end else begin
            oe_pend_d = 1'b0;
         end
      end
   end

   always_comb begin
      siod_oe = oe_q;
      wr_en   = wr_en_q;
      wr_addr = wr_q.addr;
      wr_data = wr_q.data;
      rd_addr = rd_addr_q;
      busy    = busy_q;
   end

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: drives an open-drain SCCB master against sccb_target.
// Expected register writes go into a scoreboard queue that a monitor pops on
// each wr_en; read data and line levels are checked as the master sees them.
module tb_sccb_target;
   import sccb_pkg::*;

`ifdef SCCB_ACK_DRIVE_EN
   localparam logic ACK_EXP = 1'b1;
`else
   localparam logic ACK_EXP = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       sioc;
   logic       sda;
   logic       siod_line;
   logic       siod_oe;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy;

   logic [7:0] store [256];
   sccb_wr_t   exp_q [$];
   sccb_wr_t   mon_exp;
   logic       wr_en_prev;
   int         oe_cnt;
   int         n_chk;
   int         n_fail;

   assign siod_line = sda & ~siod_oe;

   sccb_target dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sioc_in (sioc),
      .siod_in (siod_line),
      .siod_oe (siod_oe),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register store with one clock of read latency.
   always @(posedge clk) rd_data <= store[rd_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic q5();
      repeat (5) @(negedge clk);
   endtask

   task automatic bus_start();
      sioc = 1'b0; q5(); sda = 1'b1; q5(); sioc = 1'b1; q5(); q5(); sda = 1'b0; q5(); q5();
   endtask

   task automatic bus_stop();
      sioc = 1'b0; q5(); sda = 1'b0; q5(); sioc = 1'b1; q5(); q5(); sda = 1'b1; q5(); q5();
   endtask

   // One bit: data set mid-low, sampled mid-high.
   task automatic bus_bit(input logic b, output logic smp, output logic oe);
      sioc = 1'b0; q5(); sda = b; q5(); sioc = 1'b1; q5();
      smp = siod_line;
      oe  = siod_oe;
      q5();
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack_oe);
      logic s, o;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], s, o);
      bus_bit(1'b1, s, ack_oe);
   endtask

   task automatic rd_byte(input logic na, output logic [7:0] d, output logic na_oe);
      logic s, o;
      d = '0;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s, o);
         d[i] = s;
      end
      bus_bit(na, s, na_oe);
   endtask

   function automatic sccb_wr_t mk_wr(input logic [7:0] a, input logic [7:0] d);
      sccb_wr_t w;
      w.addr = a;
      w.data = d;
      return w;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack;
      logic       na_oe;
      logic [7:0] d;
      int         oe_snap;

      n_chk = 0; n_fail = 0; oe_cnt = 0; wr_en_prev = 1'b0;
      sioc = 1'b1; sda = 1'b1; rst_n = 1'b0;
      for (int i = 0; i < 256; i++) store[i] = 8'(i);
      store[8'h0A] = 8'h76;
      store[8'h0B] = 8'hA5;
      store[8'hFF] = 8'h3C;

      // Monitor: pops the scoreboard on every write strobe.
      fork
         forever begin
            @(negedge clk);
            if (siod_oe) oe_cnt++;
            if (rst_n && wr_en) begin
               chk("wr_en_width", 32'(wr_en_prev), 32'(0));
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL wr_unexpected: got addr %0h data %0h, expected no write", wr_addr, wr_data);
               end else begin
                  mon_exp = exp_q.pop_front();
                  chk("wr_addr", 32'(wr_addr), 32'(mon_exp.addr));
                  chk("wr_data", 32'(wr_data), 32'(mon_exp.data));
               end
            end
            wr_en_prev = wr_en;
         end
      join_none

      repeat (3) @(negedge clk);
      chk("rst_siod_oe", 32'(siod_oe), 32'(0));
      chk("rst_wr_en",   32'(wr_en),   32'(0));
      chk("rst_wr_addr", 32'(wr_addr), 32'(0));
      chk("rst_wr_data", 32'(wr_data), 32'(0));
      chk("rst_rd_addr", 32'(rd_addr), 32'(0));
      chk("rst_busy",    32'(busy),    32'(0));
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 3-phase write.
      bus_start();
      wr_byte(8'h42, ack); chk("t1_dev_ack", 32'(ack), 32'(ACK_EXP));
      chk("t1_busy", 32'(busy), 32'(1));
      wr_byte(8'h12, ack); chk("t1_sub_ack", 32'(ack), 32'(ACK_EXP));
      exp_q.push_back(mk_wr(8'h12, 8'h80));
      wr_byte(8'h80, ack); chk("t1_dat_ack", 32'(ack), 32'(ACK_EXP));
      bus_stop();
      chk("t1_busy_stop", 32'(busy), 32'(0));

      // Sub-address write then read.
      bus_start();
      wr_byte(8'h42, ack);
      wr_byte(8'h0A, ack);
      bus_stop();
      chk("t2_rd_addr", 32'(rd_addr), 32'(8'h0A));
      bus_start();
      wr_byte(8'h43, ack); chk("t2_dev_ack", 32'(ack), 32'(ACK_EXP));
      rd_byte(1'b1, d, na_oe);
      chk("t2_rd_data", 32'(d), 32'(8'h76));
      chk("t2_na_oe", 32'(na_oe), 32'(0));
      chk("t2_rd_addr_after", 32'(rd_addr), 32'(8'h0A));
      bus_stop();

      // Two-byte read continuing with NA=0.
      bus_start();
      wr_byte(8'h43, ack);
      rd_byte(1'b0, d, na_oe);
      chk("t2b_byte0", 32'(d), 32'(8'h76));
      rd_byte(1'b1, d, na_oe);
      chk("t2b_byte1", 32'(d), 32'(8'hA5));
      chk("t2b_rd_addr", 32'(rd_addr), 32'(8'h0B));
      bus_stop();

      // Foreign address is ignored.
      oe_snap = oe_cnt;
      bus_start();
      wr_byte(8'h60, ack); chk("t3_ack", 32'(ack), 32'(0));
      chk("t3_busy", 32'(busy), 32'(0));
      wr_byte(8'h5A, ack);
      chk("t3_busy2", 32'(busy), 32'(0));
      bus_stop();
      chk("t3_oe_never", 32'(oe_cnt - oe_snap), 32'(0));

      // Multi-byte write wraps the sub-address.
      bus_start();
      wr_byte(8'h42, ack);
      wr_byte(8'hFF, ack);
      exp_q.push_back(mk_wr(8'hFF, 8'h11));
      wr_byte(8'h11, ack);
      exp_q.push_back(mk_wr(8'h00, 8'h22));
      wr_byte(8'h22, ack);
      bus_stop();

      // Asynchronous reset while the target drives a 0 bit (store[FF]=0x3C).
      bus_start();
      wr_byte(8'h43, ack);
      sioc = 1'b0; q5(); q5();
      chk("t5_oe_driven", 32'(siod_oe), 32'(1));
      chk("t5_busy", 32'(busy), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("t5_rst_oe",      32'(siod_oe), 32'(0));
      chk("t5_rst_wr_data", 32'(wr_data), 32'(0));
      chk("t5_rst_rd_addr", 32'(rd_addr), 32'(0));
      chk("t5_rst_busy",    32'(busy),    32'(0));
      sioc = 1'b1; sda = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      bus_start();
      wr_byte(8'h42, ack);
      chk("t5_busy_after", 32'(busy), 32'(1));
      wr_byte(8'h05, ack);
      exp_q.push_back(mk_wr(8'h05, 8'h99));
      wr_byte(8'h99, ack);
      bus_stop();

      // Repeated START after 4 data bits discards the partial byte.
      bus_start();
      wr_byte(8'h42, ack); chk("t6_dev_ack", 32'(ack), 32'(ACK_EXP));
      wr_byte(8'h33, ack); chk("t6_sub_ack", 32'(ack), 32'(ACK_EXP));
      begin
         logic s, o;
         bus_bit(1'b1, s, o); bus_bit(1'b0, s, o);
         bus_bit(1'b1, s, o); bus_bit(1'b0, s, o);
      end
      bus_start();
      chk("t6_busy_rstart", 32'(busy), 32'(0));
      wr_byte(8'h42, ack); chk("t6_dev2_ack", 32'(ack), 32'(ACK_EXP));
      wr_byte(8'h33, ack);
      exp_q.push_back(mk_wr(8'h33, 8'h55));
      wr_byte(8'h55, ack); chk("t6_dat_ack", 32'(ack), 32'(ACK_EXP));
      bus_stop();

      repeat (20) @(negedge clk);
      chk("wr_missing", 32'(exp_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- SCCB responder (slave) that emulates the camera's control port so the existing SCCB master read path can be exercised in simulation and on-board loopback.
- Decodes START/STOP and device address 8'h42/8'h43.
- Accepts 3-phase writes (dev, sub-addr, data) and 2-phase sub-address writes.
- Answers 2-phase reads by serialising a byte fetched from an external register store.

Parameters:
DEV_ADDR, 8'h42, 8-bit write address; read address is DEV_ADDR|1
HOLD_CYCLES, 4, clk cycles after synchronised SIOC falling edge before target changes siod_oe (data hold)

Ports:
clk  in  1  system clock, >= 16x SIOC rate
rst_n  in  1  asynchronous active-low reset
sioc_in  in  1  SIOC from bus (asynchronous)
siod_in  in  1  SIOD from bus (asynchronous)
siod_oe  out  1  1 = pull SIOD low; 0 = release (open-drain, target never drives 1)
wr_en  out  1  one-cycle write strobe
wr_addr  out  8  write register address
wr_data  out  8  write data
rd_addr  out  8  current sub-address for read lookup
rd_data  in  8  register contents at rd_addr, valid 1 clk after rd_addr changes
busy  out  1  high from address match until STOP/START

Behaviour:
- Reset (async, rst_n=0): siod_oe=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, state IDLE, sub_addr=0, bit_cnt=0. Synchroniser flops reset to 1 (idle bus).
- Line conditioning: 2-FF sync on sioc_in/siod_in plus one delay flop. Events derived from the synced signals:
  - rise/fall = SIOC edges.
  - START = SIOD 1->0 while SIOC=1.
  - STOP = SIOD 0->1 while SIOC=1.
- Bit sampling: SIOD sampled on SIOC rise, MSB first. bit_cnt counts 0..8; bit 8 is the 9th (ack/NA) bit.
- States:
  - IDLE -> DEV on START.
  - DEV: shift 8 bits. At bit 7 rise:
    - byte==DEV_ADDR -> SUB_ACK path (next SUBA).
    - byte==DEV_ADDR|1 -> RD path.
    - else -> IGNORE.
    - busy=1 on match.
  - SUBA: 8 bits -> sub_addr, rd_addr=sub_addr at bit 7 rise; then ack bit -> WDAT.
  - WDAT: 8 bits; at bit 7 rise, wr_addr=sub_addr, wr_data=byte, wr_en=1 for exactly one clk. After the ack bit, sub_addr increments mod 256 (0xFF -> 0x00) and WDAT repeats for further bytes.
  - RD: at dev-byte bit 7 rise, capture rd_data (rd_addr already stable) into shift register. After the ack bit's SIOC fall + HOLD_CYCLES, drive bit 7. Each subsequent SIOC fall + HOLD_CYCLES presents next bit; siod_oe = ~bit. After bit 0, release for the master's NA bit.
    - NA sampled 1 -> IGNORE.
    - NA sampled 0 -> sub_addr+1, reload, continue.
  - IGNORE: siod_oe=0 until STOP/START.
- START in any state (repeated start): abort the current byte, go to DEV, siod_oe=0 immediately. sub_addr retained.
- STOP in any state: go to IDLE, busy=0, siod_oe=0 immediately. sub_addr retained. A partially received write byte is discarded (no wr_en).
- Target never changes siod_oe while synced SIOC=1, except the immediate release on START/STOP.
- Ack bit (9th bit of DEV match, SUBA, WDAT): SCCB don't-care. Default is release (see Optional Feature).
- Bus sequence master uses for reads (write DEV, SUBA, STOP, START, DEV|1, 8 bits, NA, STOP) must return the register at SUBA.

Optional Feature:
- SCCB_ACK_DRIVE_EN defined: target pulls SIOD low (siod_oe=1) during the 9th bit of matched DEV, SUBA and WDAT bytes. Asserted at SIOC fall + HOLD_CYCLES after bit 7; released at the following SIOC fall + HOLD_CYCLES.
- Not defined: siod_oe=0 throughout all ack bits (pure SCCB don't-care).

Decomposition:
- Package sccb_pkg: SCCB_CAM_ADDR=8'h42, SCCB_RD_BIT=1, state enum (IDLE, DEV, SUBA, WDAT, RD, IGNORE), BIT_ACK=4'd8.
- Sub-module sccb_line_sync: sync flops plus rise/fall/start/stop pulse generation, one instance.

Test Plan:
- 3-phase write 0x42, 0x12, 0x80, STOP -> single wr_en pulse with wr_addr=0x12, wr_data=0x80; busy falls on STOP; no other wr_en.
- Write 0x42/0x0A, STOP, START, 0x43, read with store[0x0A]=0x76 -> master decodes 0x76; rd_addr=0x0A; siod_oe low during NA bit.
- Address 0x60 then 8 bits -> siod_oe stays 0, no wr_en, busy stays 0 until STOP.
- Multi-byte write 0x42, 0xFF, 0x11, 0x22 -> wr_en at addr 0xFF (0x11) then 0x00 (0x22).
- rst_n low mid-read while siod_oe=1 -> siod_oe=0 and all outputs at reset values asynchronously; next START decodes normally.
- Repeated START after 4 bits of WDAT -> no wr_en, DEV re-entered; with SCCB_ACK_DRIVE_EN, siod_oe=1 during each 9th bit, otherwise 0.
